// File: rtl/gsau_wb_buffer.sv
// Write-back buffer between the GSAU and the vector register file write port.
// In-order queue of {psum, wbdst} with retire reporting and a pending-destination lookup.
module gsau_wb_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 512,
    parameter int unsigned DST_W  = 8
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [DATA_W-1:0]        psum,
    input  logic [DST_W-1:0]         wbdst,
    input  logic                     wb_valid,
    output logic                     output_ready,
    output logic                     rf_wen,
    output logic [DATA_W-1:0]        rf_wdata,
    output logic [DST_W-1:0]         rf_wdst,
    input  logic                     rf_ack,
    output logic                     sb_done,
    output logic [DST_W-1:0]         sb_done_dst,
    input  logic [DST_W-1:0]         q_dst,
    output logic                     q_hit,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [DST_W-1:0]  dst_mem  [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt;
    logic              enq;
    logic              deq;

    // Full/empty come from the occupancy count alone; no pop-to-push bypass when full.
    assign output_ready = (cnt != FULL);
    assign rf_wen       = (cnt != '0);
    assign enq          = wb_valid && output_ready;
    assign deq          = rf_wen && rf_ack;
    assign rf_wdata     = data_mem[rd_ptr];
    assign rf_wdst      = dst_mem[rd_ptr];
    assign count        = cnt;

    always_ff @(posedge CLK) begin
        if (enq) begin
            data_mem[wr_ptr] <= psum;
            dst_mem[wr_ptr]  <= wbdst;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cnt         <= '0;
            sb_done     <= 1'b0;
            sb_done_dst <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (deq) begin
                rd_ptr      <= rd_ptr + 1'b1;
                sb_done_dst <= dst_mem[rd_ptr];
            end
            sb_done <= deq;
            if (enq && !deq) begin
                cnt <= cnt + 1'b1;
            end else if (deq && !enq) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Only slots inside [rd_ptr, rd_ptr+cnt) may hit; pointer sum wraps at DEPTH.
    always_comb begin
        q_hit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < cnt) && (dst_mem[rd_ptr + PTR_W'(i)] == q_dst)) begin
                q_hit = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gsau_wb_buffer.sv
// Self-checking bench for gsau_wb_buffer: queue-based reference model checked every
// falling edge, plus directed scenarios with literal expectations.
module tb_gsau_wb_buffer;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned DATA_W = 512;
    localparam int unsigned DST_W  = 8;

    logic              CLK = 1'b0;
    logic              nRST;
    logic [DATA_W-1:0] psum;
    logic [DST_W-1:0]  wbdst;
    logic              wb_valid;
    logic              output_ready;
    logic              rf_wen;
    logic [DATA_W-1:0] rf_wdata;
    logic [DST_W-1:0]  rf_wdst;
    logic              rf_ack;
    logic              sb_done;
    logic [DST_W-1:0]  sb_done_dst;
    logic [DST_W-1:0]  q_dst;
    logic              q_hit;
    logic [2:0]        count;

    int n_checks = 0;
    int n_errors = 0;

    gsau_wb_buffer #(
        .DEPTH (DEPTH),
        .DATA_W(DATA_W),
        .DST_W (DST_W)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .psum        (psum),
        .wbdst       (wbdst),
        .wb_valid    (wb_valid),
        .output_ready(output_ready),
        .rf_wen      (rf_wen),
        .rf_wdata    (rf_wdata),
        .rf_wdst     (rf_wdst),
        .rf_ack      (rf_ack),
        .sb_done     (sb_done),
        .sb_done_dst (sb_done_dst),
        .q_dst       (q_dst),
        .q_hit       (q_hit),
        .count       (count)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [DST_W-1:0]  dst;
    } ent_t;

    ent_t             mq[$];
    logic             exp_done;
    logic [DST_W-1:0] exp_done_dst;

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] mk_psum(input logic [DST_W-1:0] d);
        return {64{d ^ 8'h3C}};
    endfunction

    // Reference model: a plain FIFO of entries, updated on the same edges as the DUT.
    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            mq.delete();
            exp_done     = 1'b0;
            exp_done_dst = '0;
        end else begin
            bit do_enq;
            bit do_deq;
            do_enq   = wb_valid && (mq.size() < DEPTH);
            do_deq   = (mq.size() > 0) && rf_ack;
            exp_done = do_deq;
            if (do_deq) begin
                exp_done_dst = mq[0].dst;
                void'(mq.pop_front());
            end
            if (do_enq) mq.push_back('{data: psum, dst: wbdst});
        end
    end

    always @(negedge CLK) begin
        bit hit;
        hit = 1'b0;
        foreach (mq[i]) if (mq[i].dst == q_dst) hit = 1'b1;
        check("m_count", 512'(count), 512'(mq.size()));
        check("m_output_ready", 512'(output_ready), 512'(mq.size() < DEPTH));
        check("m_rf_wen", 512'(rf_wen), 512'(mq.size() > 0));
        check("m_sb_done", 512'(sb_done), 512'(exp_done));
        check("m_q_hit", 512'(q_hit), 512'(hit));
        if (mq.size() > 0) begin
            check("m_rf_wdst", 512'(rf_wdst), 512'(mq[0].dst));
            check("m_rf_wdata", rf_wdata, mq[0].data);
        end
        if (exp_done) check("m_sb_done_dst", 512'(sb_done_dst), 512'(exp_done_dst));
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nRST     = 1'b0;
        psum     = '0;
        wbdst    = '0;
        wb_valid = 1'b0;
        rf_ack   = 1'b0;
        q_dst    = '0;

        // 1. Reset then idle
        repeat (3) @(posedge CLK);
        #1 nRST = 1'b1;
        @(negedge CLK);
        check("t1_count", 512'(count), 512'd0);
        check("t1_ready", 512'(output_ready), 512'd1);
        check("t1_rf_wen", 512'(rf_wen), 512'd0);
        check("t1_sb_done", 512'(sb_done), 512'd0);
        check("t1_q_hit", 512'(q_hit), 512'd0);
        tick();

        // 2. Single pass-through
        psum = {64{8'hA5}}; wbdst = 8'h05; wb_valid = 1'b1; rf_ack = 1'b1;
        tick();
        wb_valid = 1'b0;
        @(negedge CLK);
        check("t2_rf_wen", 512'(rf_wen), 512'd1);
        check("t2_rf_wdst", 512'(rf_wdst), 512'h05);
        check("t2_rf_wdata", rf_wdata, {64{8'hA5}});
        tick();
        @(negedge CLK);
        check("t2_sb_done", 512'(sb_done), 512'd1);
        check("t2_sb_done_dst", 512'(sb_done_dst), 512'h05);
        check("t2_count", 512'(count), 512'd0);
        tick();
        @(negedge CLK);
        check("t2_sb_done_low", 512'(sb_done), 512'd0);

        // 3. Fill and backpressure
        tick();
        rf_ack = 1'b0; wb_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wbdst = 8'h10 + 8'(k); psum = mk_psum(wbdst);
            tick();
        end
        wbdst = 8'h14; psum = mk_psum(8'h14);
        @(negedge CLK);
        check("t3_ready_full", 512'(output_ready), 512'd0);
        check("t3_count_full", 512'(count), 512'd4);
        tick();
        @(negedge CLK);
        check("t3_count_held", 512'(count), 512'd4);
        check("t3_head", 512'(rf_wdst), 512'h10);
        rf_ack = 1'b1;
        #1;
        check("t3_no_bypass", 512'(output_ready), 512'd0);
        tick();
        rf_ack = 1'b0;
        @(negedge CLK);
        check("t3_sb_done_dst", 512'(sb_done_dst), 512'h10);
        check("t3_ready_back", 512'(output_ready), 512'd1);
        check("t3_count_3", 512'(count), 512'd3);
        tick();
        wb_valid = 1'b0;
        @(negedge CLK);
        check("t3_count_refill", 512'(count), 512'd4);
        check("t3_head_11", 512'(rf_wdst), 512'h11);
        rf_ack = 1'b1;
        repeat (4) tick();
        @(negedge CLK);
        check("t3_last_retire", 512'(sb_done_dst), 512'h14);
        check("t3_empty", 512'(count), 512'd0);
        tick();

        // 4. Streaming with simultaneous push/pop across pointer wraps
        wb_valid = 1'b1; rf_ack = 1'b1;
        for (int k = 0; k < 12; k++) begin
            wbdst = 8'h20 + 8'(k); psum = mk_psum(wbdst);
            @(negedge CLK);
            if (k >= 1) begin
                check("t4_count", 512'(count), 512'd1);
                check("t4_rf_wdst", 512'(rf_wdst), 512'(8'h20 + 8'(k - 1)));
            end
            if (k >= 2) begin
                check("t4_sb_done", 512'(sb_done), 512'd1);
                check("t4_sb_done_dst", 512'(sb_done_dst), 512'(8'h20 + 8'(k - 2)));
            end
            tick();
        end
        wb_valid = 1'b0;
        @(negedge CLK);
        check("t4_tail_head", 512'(rf_wdst), 512'h2B);
        tick();
        @(negedge CLK);
        check("t4_tail_done", 512'(sb_done_dst), 512'h2B);
        check("t4_tail_empty", 512'(count), 512'd0);
        tick();

        // 5. Hazard query
        rf_ack = 1'b0; wb_valid = 1'b1;
        wbdst = 8'h30; psum = mk_psum(wbdst); tick();
        wbdst = 8'h31; psum = mk_psum(wbdst); tick();
        wb_valid = 1'b0;
        q_dst = 8'h30; @(negedge CLK); check("t5_hit_30", 512'(q_hit), 512'd1); tick();
        q_dst = 8'h31; @(negedge CLK); check("t5_hit_31", 512'(q_hit), 512'd1); tick();
        q_dst = 8'h32; @(negedge CLK); check("t5_miss_32", 512'(q_hit), 512'd0); tick();
        q_dst = 8'h30; rf_ack = 1'b1;
        @(negedge CLK); check("t5_hit_deq_cycle", 512'(q_hit), 512'd1);
        tick();
        rf_ack = 1'b0;
        @(negedge CLK); check("t5_stale_30", 512'(q_hit), 512'd0); tick();
        q_dst = 8'h31; @(negedge CLK); check("t5_hit_31_after", 512'(q_hit), 512'd1);
        rf_ack = 1'b1; tick();
        rf_ack = 1'b0;
        q_dst = 8'h33; wbdst = 8'h33; psum = mk_psum(wbdst); wb_valid = 1'b1;
        @(negedge CLK); check("t5_enq_invisible", 512'(q_hit), 512'd0);
        tick();
        wb_valid = 1'b0;
        @(negedge CLK); check("t5_enq_visible", 512'(q_hit), 512'd1);
        rf_ack = 1'b1; tick(); tick();
        rf_ack = 1'b0;

        // 6. Asynchronous reset mid-operation
        wb_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wbdst = 8'h40 + 8'(k); psum = mk_psum(wbdst);
            tick();
        end
        wb_valid = 1'b0; rf_ack = 1'b1;
        #2 nRST = 1'b0;
        #1;
        check("t6_count", 512'(count), 512'd0);
        check("t6_rf_wen", 512'(rf_wen), 512'd0);
        check("t6_sb_done", 512'(sb_done), 512'd0);
        @(posedge CLK);
        #1 nRST = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            check("t6_no_done", 512'(sb_done), 512'd0);
            check("t6_still_empty", 512'(count), 512'd0);
            tick();
        end
        rf_ack = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
